db_chroma_filter_pipe: RTL

//  Pipelined, parametrised HEVC chroma edge filter for the deblocking datapath.

---
 rtl/db_chroma_filter_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/db_chroma_filter_pipe.sv
// ----------------------------------------------------------------------------
// db_chroma_filter_pipe
// Pipelined HEVC chroma deblocking edge filter.
//
// Each beat carries LANES lines across one chroma edge (p1,p0 | q0,q1). The
// block returns the filtered p0'/q0' two cycles later when nothing stalls.
// A valid/ready handshake with backpressure is supported on both sides. A
// saturating counter tracks how many lanes were actually filtered.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid_i/ready_o  input beat handshake
//   tc_i                unsigned clip threshold (already scaled to BIT_DEPTH)
//   no_p_i / no_q_i     keep the P / Q side unchanged (pcm / lossless)
//   lane_en_i           per-lane filter enable
//   p1_i,p0_i,q0_i,q1_i lane k is bits [k*BIT_DEPTH +: BIT_DEPTH]
//   out_valid_o/ready_i output beat handshake
//   p0_o, q0_o          filtered samples, same lane packing
//   clr_i               synchronous clear of cnt_o (wins over an increment)
//   cnt_o               saturating count of modified lanes
// ----------------------------------------------------------------------------
module db_chroma_filter_pipe #(
   parameter int BIT_DEPTH = 8,
   parameter int LANES     = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [BIT_DEPTH-3:0]         tc_i,
   input  logic                         no_p_i,
   input  logic                         no_q_i,
   input  logic [LANES-1:0]             lane_en_i,
   input  logic [LANES*BIT_DEPTH-1:0]   p1_i,
   input  logic [LANES*BIT_DEPTH-1:0]   p0_i,
   input  logic [LANES*BIT_DEPTH-1:0]   q0_i,
   input  logic [LANES*BIT_DEPTH-1:0]   q1_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [LANES*BIT_DEPTH-1:0]   p0_o,
   output logic [LANES*BIT_DEPTH-1:0]   q0_o,
   input  logic                         clr_i,
   output logic [CNT_W-1:0]             cnt_o
);

   localparam int BD   = BIT_DEPTH;
   localparam int TC_W = BD - 2;
   // Four guard bits hold 4*(q0-p0) + p1 - q1 + 4 without overflow.
   localparam int W    = BD + 4;
   localparam int NM_W = $clog2(LANES + 1);
   localparam logic signed [W-1:0] C_RND = W'(4);
   localparam logic signed [W-1:0] C_MAX = W'((1 << BD) - 1);

   logic                     w_s1_adv, w_s2_adv, w_tc_nz;
   logic                     r_s1_valid, r_out_valid;
   logic [LANES-1:0][W-1:0]  w_dc, r_s1_dc;
   logic [LANES*BD-1:0]      r_s1_p0, r_s1_q0, w_p0_sat, w_q0_sat, r_p0_o, r_q0_o;
   logic [LANES-1:0]         w_mp, w_mq, w_eff, r_s1_mp, r_s1_mq, r_s1_eff;
   logic [NM_W-1:0]          w_s1_nmod, r_s2_nmod;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W:0]           w_cnt_sum;

   // Elastic pipeline control: a stage may load when it is empty or its
   // contents are leaving in the same cycle.
   assign w_s2_adv   = !r_out_valid || out_ready_i;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign in_ready_o = w_s1_adv;

   assign w_tc_nz = |tc_i;
   assign w_mp    = lane_en_i & {LANES{w_tc_nz & !no_p_i}};
   assign w_mq    = lane_en_i & {LANES{w_tc_nz & !no_q_i}};
   assign w_eff   = lane_en_i & {LANES{w_tc_nz & !(no_p_i & no_q_i)}};

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic signed [W-1:0] w_p1, w_p0, w_q0, w_q1, w_tc, w_sum, w_d;
         logic signed [W-1:0] w_dc_r, w_p0_new, w_q0_new;

         // Stage 1: filter offset, clipped to +/-tc.
         assign w_p1  = $signed({4'b0, p1_i[gi*BD +: BD]});
         assign w_p0  = $signed({4'b0, p0_i[gi*BD +: BD]});
         assign w_q0  = $signed({4'b0, q0_i[gi*BD +: BD]});
         assign w_q1  = $signed({4'b0, q1_i[gi*BD +: BD]});
         assign w_tc  = $signed({{(W-TC_W){1'b0}}, tc_i});
         assign w_sum = ((w_q0 - w_p0) <<< 2) + w_p1 - w_q1 + C_RND;
         assign w_d   = w_sum >>> 3;
         assign w_dc[gi] = (w_d > w_tc) ? w_tc : ((w_d < -w_tc) ? -w_tc : w_d);

         // Stage 2: apply offset, saturate to the sample range, honour masks.
         assign w_dc_r   = $signed(r_s1_dc[gi]);
         assign w_p0_new = $signed({4'b0, r_s1_p0[gi*BD +: BD]}) + w_dc_r;
         assign w_q0_new = $signed({4'b0, r_s1_q0[gi*BD +: BD]}) - w_dc_r;

         assign w_p0_sat[gi*BD +: BD] = !r_s1_mp[gi] ? r_s1_p0[gi*BD +: BD] :
                                        (w_p0_new < 0) ? {BD{1'b0}} :
                                        (w_p0_new > C_MAX) ? {BD{1'b1}} :
                                        w_p0_new[BD-1:0];
         assign w_q0_sat[gi*BD +: BD] = !r_s1_mq[gi] ? r_s1_q0[gi*BD +: BD] :
                                        (w_q0_new < 0) ? {BD{1'b0}} :
                                        (w_q0_new > C_MAX) ? {BD{1'b1}} :
                                        w_q0_new[BD-1:0];
      end
   endgenerate

   always_comb begin
      w_s1_nmod = '0;
      for (int k = 0; k < LANES; k++) begin
         w_s1_nmod = w_s1_nmod + NM_W'(r_s1_eff[k]);
      end
   end

   // Stage 1 register. Data only loads on a real beat so bubbles do not toggle it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_dc    <= '0;
         r_s1_p0    <= '0;
         r_s1_q0    <= '0;
         r_s1_mp    <= '0;
         r_s1_mq    <= '0;
         r_s1_eff   <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= in_valid_i;
         end
         if (w_s1_adv && in_valid_i) begin
            r_s1_dc  <= w_dc;
            r_s1_p0  <= p0_i;
            r_s1_q0  <= q0_i;
            r_s1_mp  <= w_mp;
            r_s1_mq  <= w_mq;
            r_s1_eff <= w_eff;
         end
      end
   end

   // Stage 2 register: holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_p0_o      <= '0;
         r_q0_o      <= '0;
         r_s2_nmod   <= '0;
      end else begin
         if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
         end
         if (w_s2_adv && r_s1_valid) begin
            r_p0_o    <= w_p0_sat;
            r_q0_o    <= w_q0_sat;
            r_s2_nmod <= w_s1_nmod;
         end
      end
   end

   // Carry out of the sum means the counter would wrap: clamp to all ones.
   assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(r_s2_nmod);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (r_out_valid && out_ready_i) begin
         r_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
   end

   assign out_valid_o = r_out_valid;
   assign p0_o        = r_p0_o;
   assign q0_o        = r_q0_o;
   assign cnt_o       = r_cnt;

endmodule
